fetch_ctrl: RTL

//   Program-counter/fetch sequencer that drives InstAddress of the 9-bit instruction ROM.

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Program-counter / fetch sequencer for a 2**PC_W-deep instruction ROM.
//   Start launches a program at address 0. The PC then advances every cycle,
//   or is redirected through a small writable branch-target LUT on Jump or a
//   taken BranchEn. The run ends on Halt or when the watchdog instruction
//   budget is used up, and the block then reports Done.
//
// Ports
//   Clk          clock, all state changes on the rising edge
//   Reset        synchronous, active-high; aborts any run and clears the LUT
//   Start        launch a program at PC 0 (honoured in IDLE/DONE only)
//   Halt         decoder: the current instruction is a halt
//   Jump         decoder: unconditional branch through lut[LutIdx]
//   BranchEn     decoder/ALU: conditional branch taken, through lut[LutIdx]
//   LutIdx       LUT index taken from the instruction immediate
//   LutWe        LUT write strobe (accepted in IDLE/DONE only)
//   LutWAddr     LUT write index
//   LutWData     LUT write data (branch target address)
//   InstAddress  current PC, driven straight from the PC register
//   Busy         high while a program runs
//   Done         high once a program has stopped
//   Timeout      high in DONE when the watchdog stopped the run
//   InstCount    instructions issued in the current/last run (saturating)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned LUT_AW  = 3,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  input  logic              Jump,
  input  logic              BranchEn,
  input  logic [LUT_AW-1:0] LutIdx,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutWAddr,
  input  logic [PC_W-1:0]   LutWData,
  output logic [PC_W-1:0]   InstAddress,
  output logic              Busy,
  output logic              Done,
  output logic              Timeout,
  output logic [CNT_W-1:0]  InstCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned LUT_N = 2 ** LUT_AW;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [PC_W-1:0]   lut_q [LUT_N];
  logic              lut_we;
  logic [CNT_W-1:0]  cnt_inc;
  logic              wdog_hit;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  // Compared at 32 bits so a TIMEOUT beyond the counter range never matches.
  assign wdog_hit = (TIMEOUT != 0) && (32'(cnt_inc) == TIMEOUT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    lut_we    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        lut_we = LutWe;
        if (Start) begin
          state_d   = S_RUN;
          pc_d      = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (Halt) begin
          state_d = S_DONE;                // PC holds on the halt instruction
        end else if (wdog_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (Jump || BranchEn) begin
          pc_d = lut_q[LutIdx];
        end else begin
          pc_d = pc_q + PC_W'(1);          // wraps silently at the top of the ROM
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: the LUT is a handful of flops that must read as zero after Reset,
  // so it is reset explicitly rather than left as an uninitialised RAM.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[LutWAddr] <= LutWData;
    end
  end

  assign InstAddress = pc_q;
  assign Busy        = (state_q == S_RUN);
  assign Done        = (state_q == S_DONE);
  assign Timeout     = timeout_q;
  assign InstCount   = cnt_q;

endmodule
